// File: rtl/exp_softmax_ctrl_pkg.sv
// Shared types and constants for the exp/softmax controller: FSM states,
// Q-format widths and the e^-k scale table.
package exp_softmax_ctrl_pkg;

  localparam int DATA_W     = 16;
  localparam int FRAC_W     = 11;
  localparam int SCALE_W    = 17;
  localparam int SCALE_FRAC = 16;
  localparam int K_MAX      = 8;
  localparam int K_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // round(e^-k * 65536), k = 0..K_MAX, Q1.16
  localparam logic [SCALE_W-1:0] SCALE_ROM [0:K_MAX] = '{
    17'd65536, 17'd24109, 17'd8869, 17'd3263, 17'd1200,
    17'd442,   17'd162,   17'd60,   17'd22
  };

endpackage

// File: rtl/exp_softmax_ctrl_if.sv
// Input score stream and output e^x stream of the controller.
interface exp_softmax_ctrl_if #(
  parameter int DWIDTH = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;
  logic              out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/exp_softmax_ctrl_exp_scale_rom.sv
// Integer-part scale lookup: k -> round(e^-k) in Q1.16, zero beyond K_MAX.
module exp_scale_rom
  import exp_softmax_ctrl_pkg::*;
(
  input  logic [K_W-1:0]     k,
  output logic [SCALE_W-1:0] scale
);

  localparam int ROM_DEPTH = 1 << K_W;

  logic [SCALE_W-1:0] rom [ROM_DEPTH];

  for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
    if (gi <= K_MAX) begin : g_val
      assign rom[gi] = SCALE_ROM[gi];
    end else begin : g_zero
      assign rom[gi] = '0;
    end
  end

  assign scale = rom[k];

endmodule

// File: rtl/exp_softmax_ctrl.sv
// Streams e^x for a vector of Q4.11 scores through an external 2-stage exp
// unit, rescales by e^n, and keeps a running sum of delivered results.
module exp_softmax_ctrl
  import exp_softmax_ctrl_pkg::*;
#(
  parameter int DWIDTH   = 16,
  parameter int FRAC_BIT = 11,
  parameter int LEN_W    = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  output logic                    busy,
  output logic                    done,
  output logic [DWIDTH+LEN_W-1:0] sum,
  output logic                    exp_en,
  output logic [FRAC_BIT-1:0]     exp_frac,
  input  logic [DWIDTH-1:0]       exp_out,
  exp_softmax_ctrl_if.slave       strm
);

  localparam int IW = DWIDTH - FRAC_BIT;
  localparam int SW = DWIDTH + LEN_W;
  localparam int PW = DWIDTH + SCALE_W;

  state_t             state_reg;
  logic [LEN_W-1:0]   len_reg, acc_cnt_reg, dlv_cnt_reg;
  logic [SW-1:0]      sum_reg;
  logic               busy_reg, done_reg;
  logic               s1_valid_reg, s2_valid_reg, s1_uf_reg, s2_uf_reg;
  logic [K_W-1:0]     s1_k_reg, s2_k_reg;
  logic               out_valid_reg;
  logic [DWIDTH-1:0]  out_data_reg;

  logic               adv, accept, handshake, x_neg, uf_in;
  logic [IW-1:0]      k_wide, k_in;
  logic [K_W-1:0]     k_clamp;
  logic [SCALE_W-1:0] scale;
  logic [PW-1:0]      prod;
  logic [DWIDTH-1:0]  out_next;

  assign adv       = !out_valid_reg || strm.out_ready;
  assign exp_en    = adv;
  assign strm.in_ready = (state_reg == ST_LOAD) && (acc_cnt_reg < len_reg) && adv;
  assign accept    = strm.in_valid && strm.in_ready;
  assign handshake = out_valid_reg && strm.out_ready;

  // n = floor(x) is negative for negative x, so k = -n; positive x clamps to 0
  assign x_neg    = strm.in_data[DWIDTH-1];
  assign k_wide   = ~strm.in_data[DWIDTH-1:FRAC_BIT] + IW'(1);
  assign k_in     = x_neg ? k_wide : '0;
  assign uf_in    = int'(k_in) > K_MAX;
  assign k_clamp  = uf_in ? K_W'(K_MAX) : k_in[K_W-1:0];
  assign exp_frac = (accept && x_neg) ? strm.in_data[FRAC_BIT-1:0] : '0;

  exp_scale_rom u_scale_rom (
    .k     (s2_k_reg),
    .scale (scale)
  );

  assign prod     = PW'(exp_out) * PW'(scale);
  assign out_next = (s2_valid_reg && !s2_uf_reg) ? DWIDTH'(prod >> SCALE_FRAC) : '0;

  // Sideband stages move only with exp_en so they stay aligned with exp_out
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
      s1_uf_reg     <= 1'b0;
      s2_uf_reg     <= 1'b0;
      s1_k_reg      <= '0;
      s2_k_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (adv) begin
      s1_valid_reg  <= accept;
      s1_uf_reg     <= uf_in;
      s1_k_reg      <= k_clamp;
      s2_valid_reg  <= s1_valid_reg;
      s2_uf_reg     <= s1_uf_reg;
      s2_k_reg      <= s1_k_reg;
      out_valid_reg <= s2_valid_reg;
      out_data_reg  <= out_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      len_reg     <= '0;
      acc_cnt_reg <= '0;
      dlv_cnt_reg <= '0;
      sum_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) acc_cnt_reg <= acc_cnt_reg + LEN_W'(1);
      if (handshake) begin
        dlv_cnt_reg <= dlv_cnt_reg + LEN_W'(1);
        sum_reg     <= sum_reg + SW'(out_data_reg);
      end
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            len_reg     <= len;
            acc_cnt_reg <= '0;
            dlv_cnt_reg <= '0;
            sum_reg     <= '0;
            busy_reg    <= 1'b1;
            if (len == '0) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (accept && acc_cnt_reg == len_reg - LEN_W'(1)) state_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (handshake && dlv_cnt_reg == len_reg - LEN_W'(1)) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign strm.out_valid = out_valid_reg;
  assign strm.out_data  = out_data_reg;
  assign strm.out_last  = out_valid_reg && (dlv_cnt_reg == len_reg - LEN_W'(1));
  assign sum  = sum_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_exp_softmax_ctrl.sv
// Directed and randomized checks of exp_softmax_ctrl against a real-arithmetic
// model of e^x, with a behavioural 2-stage exp unit attached.
module tb_exp_softmax_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  len = '0;
  logic        busy, done;
  logic [22:0] sum;
  logic        exp_en;
  logic [10:0] exp_frac;
  logic [15:0] exp_out;
  logic [15:0] e1 = '0, e2 = '0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] xs[$];
  int exp_q[$];
  int got_q[$];

  exp_softmax_ctrl_if #(.DWIDTH(16)) bus ();

  exp_softmax_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .exp_en   (exp_en),
    .exp_frac (exp_frac),
    .exp_out  (exp_out),
    .strm     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_unit_fn(input logic [10:0] f);
    return 16'($rtoi($exp($itor(f) / 2048.0) * 2048.0 + 0.5));
  endfunction

  // Behavioural exp unit: two enabled register stages
  always @(posedge clk) begin
    if (exp_en) begin
      e1 <= exp_unit_fn(exp_frac);
      e2 <= e1;
    end
  end
  assign exp_out = e2;

  // e^x from the number rules: split x into floor and fraction, scale e^f by e^n
  function automatic int ref_exp(input logic [15:0] x);
    real xr, nf, f;
    int n;
    longint e, s;
    xr = $itor($signed(x)) / 2048.0;
    if (xr > 0.0) xr = 0.0;
    nf = $floor(xr);
    f  = xr - nf;
    n  = $rtoi(nf);
    if (n < -8) return 0;
    e = longint'($rtoi($exp(f) * 2048.0 + 0.5));
    s = longint'($rtoi($exp($itor(n)) * 65536.0 + 0.5));
    return int'((e * s) >> 16);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic run_vec(input int n, input bit rnd_valid, input bit rnd_ready,
                         input bit rnd_start, input int stall_len);
    int in_idx, out_idx, cyc, stall_left, sum_exp;
    bit stalled;
    exp_q.delete();
    got_q.delete();
    foreach (xs[i]) exp_q.push_back(ref_exp(xs[i]));
    @(negedge clk);
    start = 1'b1; len = 7'(n); bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    in_idx = 0; out_idx = 0; cyc = 0; stall_left = stall_len; sum_exp = 0;
    while (out_idx < n && cyc < 2000) begin
      bus.in_valid = (in_idx < n) && (!rnd_valid || $urandom_range(0, 3) != 0);
      bus.in_data  = (in_idx < n) ? xs[in_idx] : 16'h0;
      start = rnd_start && ($urandom_range(0, 7) == 0);
      len   = 7'($urandom_range(0, 127));
      stalled = (stall_left > 0) && bus.out_valid;
      if (stalled) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = !rnd_ready || ($urandom_range(0, 1) == 1);
      end
      #1;
      chk("busy_in_run", 32'(busy), 1);
      chk("done_early", 32'(done), 0);
      if (stalled) begin
        chk("stall_hold", 32'(bus.out_data), exp_q[out_idx]);
        chk("stall_in_ready", 32'(bus.in_ready), 0);
      end
      if (bus.in_valid && bus.in_ready) in_idx++;
      if (bus.out_valid && bus.out_ready) begin
        chk("out_data", 32'(bus.out_data), exp_q[out_idx]);
        chk("out_last", 32'(bus.out_last), 32'(out_idx == n - 1));
        got_q.push_back(int'(bus.out_data));
        sum_exp += exp_q[out_idx];
        out_idx++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    chk("out_count", out_idx, n);
    chk("in_count", in_idx, n);
    chk("done_pulse", 32'(done), 1);
    chk("sum", 32'(sum), sum_exp);
    chk("drained", 32'(bus.out_valid), 0);
    @(negedge clk);
    chk("done_end", 32'(done), 0);
    chk("busy_end", 32'(busy), 0);
    chk("sum_hold", 32'(sum), sum_exp);
    $display("vector len=%0d outputs=%0d sum=%0d", n, out_idx, sum);
  endtask

  initial begin
    int acc;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_out_last", 32'(bus.out_last), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    rst = 1'b0;

    // Single zero score
    xs = '{16'h0000};
    run_vec(1, 0, 0, 0, 0);
    chk("single_data", got_q[0], 2048);
    chk("single_sum", 32'(sum), 2048);

    // -1.0 then -0.5
    xs = '{16'hF800, 16'hFC00};
    run_vec(2, 0, 0, 0, 0);
    chk("neg1_data", got_q[0], 753);
    chk("neghalf_data", got_q[1], 1242);
    chk("neg_sum", 32'(sum), 1995);

    // Underflow then positive clamp
    xs = '{16'hB800, 16'h0400};
    run_vec(2, 0, 0, 0, 0);
    chk("uflow_data", got_q[0], 0);
    chk("clamp_data", got_q[1], 2048);

    // Backpressure right after the first result
    xs = '{16'h0, 16'h0, 16'h0, 16'h0};
    run_vec(4, 0, 0, 0, 5);
    chk("stall_count", got_q.size(), 4);
    chk("stall_sum", 32'(sum), 8192);

    // Empty vector
    @(negedge clk);
    start = 1'b1; len = 7'd0;
    @(negedge clk);
    start = 1'b0;
    chk("len0_busy", 32'(busy), 1);
    chk("len0_done", 32'(done), 1);
    chk("len0_sum", 32'(sum), 0);
    chk("len0_out_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    chk("len0_done_end", 32'(done), 0);
    chk("len0_busy_end", 32'(busy), 0);
    $display("vector len=0 sum=%0d", sum);

    // Reset in the middle of a vector
    start = 1'b1; len = 7'd4;
    @(negedge clk);
    start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'h0; bus.out_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 20 && acc < 2; c++) begin
      #1;
      if (bus.in_valid && bus.in_ready) acc++;
      @(negedge clk);
    end
    chk("mid_accepts", acc, 2);
    bus.in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_out_data", 32'(bus.out_data), 0);
    chk("mid_rst_sum", 32'(sum), 0);
    for (int c = 0; c < 6; c++) begin
      chk("mid_rst_no_done", 32'(done), 0);
      chk("mid_rst_no_out", 32'(bus.out_valid), 0);
      @(negedge clk);
    end
    $display("reset mid-vector after %0d accepts", acc);
    xs = '{16'h0000};
    run_vec(1, 0, 0, 0, 0);
    chk("post_rst_data", got_q[0], 2048);

    // Random scores, random gaps, random backpressure, ignored starts
    for (int v = 0; v < 8; v++) begin
      int n;
      n = $urandom_range(1, 12);
      xs.delete();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) != 0) xs.push_back(16'(-$urandom_range(0, 20000)));
        else xs.push_back(16'($urandom_range(0, 65535)));
      end
      run_vec(n, 1, 1, 1, (v == 3) ? 3 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
